pulse_display_driver: RTL and testbench



---
 rtl/pulse_display_driver_if.sv | 39 +++
 rtl/pulse_display_driver.sv | 124 ++++++++++++
 tb/tb_pulse_display_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_display_driver_if
// Description : Event-strobe / display-pulse bundle for pulse_display_driver.
//               master : event producer (drives req, observes status)
//               slave  : the display driver (samples req, drives status)
//   req      - single-cycle event strobe
//   out      - registered display pulse to LED/pin
//   busy     - driver is showing a pulse or gap
//   pending  - queued events not yet shown
//   overflow - sticky, an event was dropped at saturation
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_display_driver_if #(
    parameter int PW = 3
);
    logic          req;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    modport master (
        output req,
        input  out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  req,
        output out,
        output busy,
        output pending,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/pulse_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : pulse_display_driver
// Description : Stretches single-cycle event strobes into visible pulses of
//               HOLD_CYCLES high with at least GAP_CYCLES low in between.
//               Strobes arriving while a pulse is shown are counted and
//               replayed one by one; the count saturates at MAX_PEND and
//               raises a sticky overflow flag.
// Ports       : clk   - system clock (rising edge)
//               reset - asynchronous, active-high reset
//               bus   - slave side of pulse_display_driver_if
//                       (req in; out, busy, pending, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_display_driver #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PEND    = 7,
    parameter int PW          = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pulse_display_driver_if.slave bus
);

    localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    // The counter is loaded with (length-1) on state entry and the state is
    // left on the edge where it reads zero, giving exactly 'length' cycles.
    localparam logic [c_cw-1:0] c_hold_load = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0] c_gap_load  = c_cw'(GAP_CYCLES - 1);
    localparam logic [PW-1:0]   c_max_pend  = PW'(MAX_PEND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [c_cw-1:0] cnt_q;
    logic [PW-1:0]   pending_q;
    logic            out_q;
    logic            busy_q;
    logic            overflow_q;

    logic            w_full;
    assign w_full = (pending_q == c_max_pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The triggering strobe is shown directly, never queued.
                    if (bus.req) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= c_hold_load;
                        out_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (bus.req) begin
                        if (w_full) overflow_q <= 1'b1;
                        else        pending_q  <= pending_q + PW'(1);
                    end
                    if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= c_gap_load;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - c_cw'(1);
                    end
                end

                ST_GAP: begin
                    if (cnt_q != '0) begin
                        if (bus.req) begin
                            if (w_full) overflow_q <= 1'b1;
                            else        pending_q  <= pending_q + PW'(1);
                        end
                        cnt_q <= cnt_q - c_cw'(1);
                    end else if ((pending_q != '0) || bus.req) begin
                        // Final gap edge: one event is consumed by the new
                        // pulse. A simultaneous strobe replaces it in the
                        // queue, so the count only drops when req is low and
                        // can never overflow here.
                        state_q <= ST_HIGH;
                        cnt_q   <= c_hold_load;
                        out_q   <= 1'b1;
                        if ((pending_q != '0) && !bus.req)
                            pending_q <= pending_q - PW'(1);
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_display_driver
// Description : Self-checking bench for pulse_display_driver. A timeline
//               model (time since current pulse start + queued-event count)
//               predicts out/busy/pending/overflow after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_display_driver;

    localparam int HOLD_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int MAX_PEND    = 3;
    localparam int PW          = 2;
    localparam int PERIOD      = HOLD_CYCLES + GAP_CYCLES;

    logic clk;
    logic reset;

    pulse_display_driver_if #(.PW(PW)) bus ();

    pulse_display_driver #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .MAX_PEND    (MAX_PEND),
        .PW          (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: is a pulse/gap sequence active, how many cycles since
    // the current pulse started, queued events, sticky drop flag.
    bit m_active;
    int m_t;
    int m_pend;
    bit m_ovf;

    int  rises;
    logic prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input bit r);
        if (!m_active) begin
            if (r) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (m_t == PERIOD - 1) begin
            if (m_pend > 0 || r) begin
                if (m_pend > 0 && !r) m_pend--;
                m_t = 0;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t++;
            if (r) begin
                if (m_pend == MAX_PEND) m_ovf = 1'b1;
                else                    m_pend++;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [PW-1:0] exp_p;
        exp_p = m_pend[PW-1:0];
        chk({ctx, ".out"},      {31'd0, bus.out},      {31'd0, m_active && (m_t < HOLD_CYCLES)});
        chk({ctx, ".busy"},     {31'd0, bus.busy},     {31'd0, m_active});
        chk({ctx, ".pending"},  {30'd0, bus.pending},  {30'd0, exp_p});
        chk({ctx, ".overflow"}, {31'd0, bus.overflow}, {31'd0, m_ovf});
    endtask

    task automatic tick(input bit r, input string ctx);
        @(negedge clk);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        if (bus.out === 1'b1 && prev_out !== 1'b1) rises++;
        prev_out = bus.out;
        check_all(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) tick(1'b0, ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = 1'b0;
        reset   = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset    = 1'b0;
        prev_out = 1'b0;
    endtask

    initial begin
        bus.req  = 1'b0;
        reset    = 1'b1;
        prev_out = 1'b0;
        rises    = 0;
        model_reset();
        #1;
        check_all("por");

        // Single event: 4 high, 2 low, back to idle.
        do_reset();
        idle(3, "single.pre");
        tick(1'b1, "single");
        idle(10, "single.run");

        // Second event during the first pulse is replayed after the gap.
        do_reset();
        tick(1'b1, "two");
        tick(1'b0, "two");
        tick(1'b1, "two");
        chk("two.pending", {30'd0, bus.pending}, 32'd1);
        idle(14, "two.run");

        // Saturation: five back-to-back strobes, fourth queued one dropped.
        do_reset();
        rises = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, "sat");
        chk("sat.overflow", {31'd0, bus.overflow}, 32'd1);
        idle(4 * PERIOD + 4, "sat.run");
        chk("sat.pulses", rises, 32'd4);
        chk("sat.overflow_sticky", {31'd0, bus.overflow}, 32'd1);

        // Strobe exactly on the final gap edge: immediate new pulse.
        do_reset();
        tick(1'b1, "lastgap");
        idle(PERIOD - 1, "lastgap.wait");
        tick(1'b1, "lastgap.hit");
        chk("lastgap.out",  {31'd0, bus.out},  32'd1);
        chk("lastgap.busy", {31'd0, bus.busy}, 32'd1);
        idle(PERIOD + 2, "lastgap.run");

        // Asynchronous reset in the middle of a pulse with two queued.
        do_reset();
        tick(1'b1, "areset");
        tick(1'b1, "areset");
        tick(1'b1, "areset");
        chk("areset.pending_before", {30'd0, bus.pending}, 32'd2);
        @(negedge clk);
        bus.req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("areset.async");
        @(negedge clk);
        reset    = 1'b0;
        prev_out = 1'b0;
        rises    = 0;
        idle(3 * PERIOD, "areset.after");
        chk("areset.no_resume", rises, 32'd0);

        // req held high for three edges = three events.
        do_reset();
        rises = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, "held");
        chk("held.pending", {30'd0, bus.pending}, 32'd2);
        idle(3 * PERIOD + 2, "held.run");
        chk("held.pulses", rises, 32'd3);

        // Randomized strobes with varying density.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int dens;
            dens = (i < 200) ? 4 : 12;
            tick(($urandom_range(0, dens - 1) == 0), "rand");
        end
        idle(MAX_PEND * PERIOD + PERIOD, "rand.drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
